// File: rtl/jts16_fd1094_keyload.sv
// FD1094 key loader: extracts the 8 KB key region from the 16-bit download stream and writes it bytewise into the key RAM.
// Optional running byte checksum on key_sum when JTS16_FD1094_SUM_EN is defined.
module jts16_fd1094_keyload #(
  parameter int             AW       = 25,
  parameter logic [AW-1:0]  KEY_BASE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dwn_en,
  input  logic [AW-1:0] dwn_addr,
  input  logic [15:0]   dwn_data,
  input  logic          dwn_valid,
  output logic          dwn_ready,
  output logic [12:0]   prog_addr,
  output logic [7:0]    prog_data,
  output logic          fd1094_we,
  output logic          key_done,
  output logic          key_err,
  output logic [15:0]   key_sum
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [AW:0] BASE_EXT = {1'b0, KEY_BASE};
  localparam logic [AW:0] END_EXT  = BASE_EXT + (AW+1)'(8192);

  state_t        state;
  logic [15:0]   word_q;
  logic [12:0]   off_q;
  logic [13:0]   ptr;
  logic          done_pend;
  logic          en_q;

  logic [AW:0]   addr_even;
  logic [AW:0]   off_full;
  logic [12:0]   off;
  logic          in_range;
  logic          accept;
  logic          en_rise;
  logic [13:0]   ptr_eff;

  assign addr_even = {1'b0, dwn_addr[AW-1:1], 1'b0};
  assign off_full  = addr_even - BASE_EXT;
  assign off       = off_full[12:0];
  assign in_range  = (addr_even >= BASE_EXT) && (addr_even < END_EXT);
  assign accept    = dwn_valid && dwn_ready && in_range;
  assign en_rise   = dwn_en && !en_q;
  // A word checked in the same cycle as a session restart sees the cleared pointer
  assign ptr_eff   = en_rise ? 14'd0 : ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_q    <= '0;
      off_q     <= '0;
      ptr       <= '0;
      done_pend <= 1'b0;
      en_q      <= 1'b0;
      dwn_ready <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      fd1094_we <= 1'b0;
      key_done  <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      en_q <= dwn_en;
      if (en_rise) begin
        ptr      <= '0;
        key_done <= 1'b0;
        key_err  <= 1'b0;
      end
      case (state)
        LO: begin
          fd1094_we <= 1'b1;
          prog_addr <= {off_q[12:1], 1'b1};
          prog_data <= word_q[15:8];
          dwn_ready <= 1'b1;
          state     <= HI;
          if (off_q != ptr_eff[12:0] || ptr_eff == 14'd8192) key_err <= 1'b1;
          ptr       <= {1'b0, off_q} + 14'd2;
          done_pend <= (ptr_eff == 14'd8190) && (off_q == 13'd8190);
        end
        default: begin
          // IDLE and HI both accept the next word; HI also finalises key_done
          if (state == HI && done_pend && !key_err && !en_rise) key_done <= 1'b1;
          if (accept) begin
            word_q    <= dwn_data;
            off_q     <= off;
            fd1094_we <= 1'b1;
            prog_addr <= off;
            prog_data <= dwn_data[7:0];
            dwn_ready <= 1'b0;
            state     <= LO;
          end else begin
            fd1094_we <= 1'b0;
            dwn_ready <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef JTS16_FD1094_SUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_sum <= '0;
    end else begin
      key_sum <= (en_rise ? 16'd0 : key_sum) + (fd1094_we ? {8'd0, prog_data} : 16'd0);
    end
  end
`else
  assign key_sum = 16'd0;
`endif

endmodule
